// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester, register-file write and issue scoreboard signals
interface regfile_wb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic                a_valid;
    logic [AW-1:0]       a_addr;
    logic [DW-1:0]       a_data;
    logic                a_ready;
    logic                b_valid;
    logic [AW-1:0]       b_addr;
    logic [DW-1:0]       b_data;
    logic                b_ready;
    logic                RegWrite;
    logic [AW-1:0]       wn;
    logic [DW-1:0]       wd;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ready;
    logic [AW-1:0]       rs;
    logic [AW-1:0]       rt;
    logic                hazard;
    logic [(2**AW)-1:0]  busy;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output rsv_valid, rsv_addr, rs, rt,
        input  a_ready, b_ready, RegWrite, wn, wd, rsv_ready, hazard, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  rsv_valid, rsv_addr, rs, rt,
        output a_ready, b_ready, RegWrite, wn, wd, rsv_ready, hazard, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register-file write port with busy scoreboard
module regfile_wb_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int NREG = 2 ** AW;

    typedef enum logic {LAST_A, LAST_B} last_e;

    last_e             last_q, last_d;
    logic              regwrite_q;
    logic [AW-1:0]     wn_q;
    logic [DW-1:0]     wd_q;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              grant_a, grant_b, accept, rsv_ok;
    logic [AW-1:0]     acc_addr;
    logic [DW-1:0]     acc_data;

    // Pointer holds the last winner; on a tie the other requester is granted.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (rst) begin
            if (bus.a_valid && (!bus.b_valid || last_q == LAST_B)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
        if (grant_a) begin
            last_d = LAST_A;
        end else if (grant_b) begin
            last_d = LAST_B;
        end
    end

    assign accept   = grant_a | grant_b;
    assign acc_addr = grant_a ? bus.a_addr : bus.b_addr;
    assign acc_data = grant_a ? bus.a_data : bus.b_data;

    assign rsv_ok = rst && ((bus.rsv_addr == '0) || !busy_q[bus.rsv_addr]);

    // Reservation is applied after the commit clear so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (regwrite_q) begin
            busy_d[wn_q] = 1'b0;
        end
        if (bus.rsv_valid && rsv_ok) begin
            busy_d[bus.rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= LAST_B;
            regwrite_q <= 1'b0;
            wn_q       <= '0;
            wd_q       <= '0;
            busy_q     <= '0;
        end else begin
            last_q     <= last_d;
            regwrite_q <= accept && (acc_addr != '0);
            if (accept && (acc_addr != '0)) begin
                wn_q <= acc_addr;
                wd_q <= acc_data;
            end
            busy_q     <= busy_d;
        end
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.RegWrite  = regwrite_q;
    assign bus.wn        = wn_q;
    assign bus.wd        = wd_q;
    assign bus.rsv_ready = rsv_ok;
    assign bus.busy      = busy_q;
    // No forwarding: a register stays hazardous through its RegWrite cycle.
    assign bus.hazard    = ((bus.rs != '0) && busy_q[bus.rs]) ||
                           ((bus.rt != '0) && busy_q[bus.rt]);
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wn/wd/RegWrite) between two writeback requesters: A = ALU path, B = load/multicycle unit.
- Uses valid/ready handshakes and round-robin arbitration.
- Holds a 32-entry busy scoreboard: issue reserves a destination, and the register is released when its write commits. Issue uses the scoreboard for RAW hazard stalls.
- Sits between the writeback sources and the RegisterFile write port; drives RegWrite, wn and wd directly.

Parameters:
AW, 5, register address width (2**AW registers)
DW, 32, register data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
a_valid  input  1  requester A has a write
a_addr  input  AW  requester A destination
a_data  input  DW  requester A data
a_ready  output  1  requester A accepted this cycle
b_valid  input  1  requester B has a write
b_addr  input  AW  requester B destination
b_data  input  DW  requester B data
b_ready  output  1  requester B accepted this cycle
RegWrite  output  1  register file write enable (registered)
wn  output  AW  register file write address (registered)
wd  output  DW  register file write data (registered)
rsv_valid  input  1  issue requests reservation of rsv_addr
rsv_addr  input  AW  register to reserve
rsv_ready  output  1  reservation accepted
rs  input  AW  issue source operand 1
rt  input  AW  issue source operand 2
hazard  output  1  an operand is pending a write
busy  output  2**AW  scoreboard bit vector (registered)

Behaviour:
- Reset (rst=0, asynchronous): RegWrite=0, wn=0, wd=0, busy=0, round-robin pointer set so A wins the next tie.
  - An in-flight write is dropped; RegWrite falls immediately, without waiting for a clock edge.
  - Inputs are ignored while rst=0.
- Arbitration (combinational ready, at most one grant per cycle):
  - Only one valid -> that requester is granted.
  - Both valid -> the requester not granted most recently wins.
  - Neither valid -> no grant, pointer unchanged.
  - The pointer records the last granted requester and updates on every grant.
  - a_ready = grant_A, b_ready = grant_B.
  - ready is never high when the corresponding valid is low.
  - Requesters must hold addr/data stable while valid && !ready.
- Write commit: the accept edge is cycle k.
  - Cycle k+1: RegWrite=1, wn=addr, wd=data. The register file writes at the end of k+1.
  - RegWrite is 0 in any cycle following an edge with no accept.
  - Throughput is one write per cycle with no bubbles; the register file never backpressures.
- Register 0: an accepted write with addr=0 completes the handshake normally.
  - RegWrite stays 0, and the pointer still updates.
- Scoreboard:
  - busy[i] sets on an edge with rsv_valid && rsv_ready && rsv_addr=i.
  - busy[i] clears on an edge where RegWrite=1 && wn=i.
  - The register file holds the new value in the cycle after the clear.
  - Set and clear of the same index on the same edge -> set wins (busy stays 1).
  - busy[0] is hardwired to 0; a reservation of register 0 is accepted and has no effect.
- rsv_ready = (rsv_addr==0) || !busy[rsv_addr], computed from the registered busy vector.
  - A bit being cleared this edge still reads busy, so ready stays 0 that cycle.
  - rsv_valid with rsv_ready=0 is ignored; issue must retry.
- hazard = (rs!=0 && busy[rs]) || (rt!=0 && busy[rt]).
  - Combinational from the registered busy vector only; it does not forward the pending RegWrite.
- The scoreboard does not check that writes correspond to reservations. A write to an unreserved register commits and clears nothing extra.

Test Plan:
- Reset, then a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one cycle -> a_ready=1 that cycle; next cycle RegWrite=1, wn=5, wd=32'hDEADBEEF; the cycle after that, RegWrite=0.
- A and B both valid continuously for 4 cycles, addresses 1 and 2 -> grants A,B,A,B; RegWrite=1 in 4 consecutive cycles with wn=1,2,1,2.
- rsv_valid=1, rsv_addr=7 -> busy[7]=1 next cycle; rs=7 -> hazard=1.
  - Continue: B writes reg 7 -> hazard stays 1 during the RegWrite cycle and drops the cycle after.
  - Continue: a second reservation of 7 while busy -> rsv_ready=0.
- Reserve 9 on the same edge that RegWrite=1, wn=9 commits -> busy[9]=1 after the edge (set wins).
- a_addr=0 accepted -> a_ready=1; RegWrite stays 0. Then rsv_addr=0 -> rsv_ready=1, busy[0]=0; rs=0, rt=0 -> hazard=0.
- Assert rst=0 mid-cycle while RegWrite=1 and busy=32'h0000_0F00 -> RegWrite=0 and busy=0 immediately, before any clock edge. After release, a tie is granted to A.
